// File: rtl/fft_pkg.sv
// Shared sizing defaults and bank-state encoding for the FFT framing path.
// Imported by the frame buffer top and its per-bank register file.
package fft_pkg;

    localparam int DATA_W_D    = 16;
    localparam int FRAME_LEN_D = 16;

    typedef logic [1:0] bank_st_t;

    localparam bank_st_t BK_EMPTY    = 2'd0;
    localparam bank_st_t BK_FILLING  = 2'd1;
    localparam bank_st_t BK_FULL     = 2'd2;
    localparam bank_st_t BK_DRAINING = 2'd3;

    // A bank holding a complete frame belongs to the reader.
    function automatic logic bank_busy(input bank_st_t s);
        return (s == BK_FULL) || (s == BK_DRAINING);
    endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of sample storage: single write port, combinational read,
// and the EMPTY/FILLING/FULL/DRAINING lifecycle of the bank.
module frame_bank
    import fft_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_D,
    parameter int  FRAME_LEN = FRAME_LEN_D,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_hs,
    input  logic              i_rd_last,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata,
    output bank_st_t          o_state
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];
    bank_st_t          r_state;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_widx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_ridx];
    assign o_state = r_state;

    // Writes and reads never target the same bank on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= BK_EMPTY;
        else if (i_we && (i_widx == LAST))
            r_state <= BK_FULL;
        else if (i_we)
            r_state <= BK_FILLING;
        else if (i_rd_hs && i_rd_last)
            r_state <= BK_EMPTY;
        else if (i_rd_hs)
            r_state <= BK_DRAINING;
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the FIR output and the FFT input:
// fills one bank while the other drains, dropping samples when both are full.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_D,
    parameter int  FRAME_LEN = FRAME_LEN_D,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fir_valid,
    input  logic [DATA_W-1:0] fir_d,
    input  logic              frm_ready,
    output logic              frm_valid,
    output logic [DATA_W-1:0] frm_data,
    output logic [IDX_W-1:0]  frm_idx,
    output logic              frm_last,
    output logic              overflow
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_overflow;

    bank_st_t          w_st    [2];
    logic [DATA_W-1:0] w_rdata [2];

    logic w_wr_ok;
    logic w_we;
    logic w_wr_last;
    logic w_valid;
    logic w_hs;
    logic w_rd_last;

    assign w_wr_ok   = !bank_busy(w_st[r_wr_bank]);
    assign w_we      = fir_valid && w_wr_ok;
    assign w_wr_last = (r_wr_idx == LAST);
    assign w_valid   = bank_busy(w_st[r_rd_bank]);
    assign w_hs      = w_valid && frm_ready;
    assign w_rd_last = (r_rd_idx == LAST);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank #(
            .DATA_W    (DATA_W),
            .FRAME_LEN (FRAME_LEN)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_we && (r_wr_bank == 1'(b))),
            .i_widx    (r_wr_idx),
            .i_wdata   (fir_d),
            .i_rd_hs   (w_hs && (r_rd_bank == 1'(b))),
            .i_rd_last (w_rd_last),
            .i_ridx    (r_rd_idx),
            .o_rdata   (w_rdata[b]),
            .o_state   (w_st[b])
        );
    end

    // Storage is not cleared by reset, so gate the data path on valid.
    assign frm_valid = w_valid;
    assign frm_data  = w_valid ? w_rdata[r_rd_bank] : '0;
    assign frm_idx   = r_rd_idx;
    assign frm_last  = w_valid && w_rd_last;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_idx <= w_wr_last ? '0 : r_wr_idx + IDX_W'(1);
                if (w_wr_last)
                    r_wr_bank <= ~r_wr_bank;
            end
            if (fir_valid && !w_wr_ok)
                r_overflow <= 1'b1;
            if (w_hs) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + IDX_W'(1);
                if (w_rd_last)
                    r_rd_bank <= ~r_rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Randomised bench for fft_frame_buffer against a frame-queue reference.
module tb_fft_frame_buffer;

    localparam int DW = 16;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fir_valid = 1'b0;
    logic [DW-1:0] fir_d = '0;
    logic          frm_ready = 1'b0;
    logic          frm_valid;
    logic [DW-1:0] frm_data;
    logic [3:0]    frm_idx;
    logic          frm_last;
    logic          overflow;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: completed-frame words awaiting output, plus partial frame.
    logic [DW-1:0] outq [$];
    logic [DW-1:0] part [$];
    bit            m_ovf;

    always #5 clk = ~clk;

    fft_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .frm_ready (frm_ready),
        .frm_valid (frm_valid),
        .frm_data  (frm_data),
        .frm_idx   (frm_idx),
        .frm_last  (frm_last),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frames_held();
        return (outq.size() + FL - 1) / FL;
    endfunction

    task automatic model_edge(input bit v, input logic [DW-1:0] d,
                              input bit rdy);
        int fr;
        fr = frames_held();
        if (outq.size() > 0 && rdy)
            void'(outq.pop_front());
        if (v) begin
            if (fr < 2) begin
                part.push_back(d);
                if (part.size() == FL) begin
                    foreach (part[i]) outq.push_back(part[i]);
                    part.delete();
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare();
        bit exp_v;
        int exp_idx;
        exp_v = outq.size() > 0;
        chk("valid", 32'(frm_valid), 32'(exp_v));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (exp_v) begin
            exp_idx = (FL - (outq.size() % FL)) % FL;
            chk("data", 32'(frm_data), 32'(outq[0]));
            chk("idx", 32'(frm_idx), 32'(exp_idx));
            chk("last", 32'(frm_last), 32'(exp_idx == FL - 1));
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d,
                        input bit rdy, output bit hs);
        @(negedge clk);
        fir_valid = v;
        fir_d     = d;
        frm_ready = rdy;
        #1 hs = frm_valid && rdy;
        @(posedge clk);
        model_edge(v, d, rdy);
        #1 compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        fir_valid = 1'b0;
        frm_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(frm_valid), 0);
        chk("rst_data", 32'(frm_data), 0);
        chk("rst_idx", 32'(frm_idx), 0);
        chk("rst_last", 32'(frm_last), 0);
        chk("rst_ovf", 32'(overflow), 0);
        outq.delete();
        part.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        bit hs;
        repeat (n) step(1'b0, '0, 1'b1, hs);
    endtask

    initial begin
        bit hs;
        int cnt;

        // Single frame 1..16, then drain.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, hs);
        chk("first_rise", 32'(frm_valid), 1);
        drain(20);

        // Continuous 48-sample stream, consumer always ready.
        do_reset();
        for (int i = 0; i < 48; i++) step(1'b1, DW'($urandom), 1'b1, hs);
        drain(20);
        chk("stream_ovf", 32'(overflow), 0);

        // Consumer stalled for 40 samples: last 8 are dropped.
        do_reset();
        for (int i = 1; i <= 40; i++) step(1'b1, DW'(i), 1'b0, hs);
        chk("stall_ovf", 32'(overflow), 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, '0, 1'b1, hs);
            if (hs) cnt++;
        end
        chk("stall_words", 32'(cnt), 32);

        // Ready toggling every cycle.
        do_reset();
        for (int i = 0; i < 48; i++)
            step(1'b1, DW'($urandom), 1'(i % 2), hs);
        for (int i = 0; i < 70; i++) step(1'b0, '0, 1'(i % 2), hs);

        // Gap of 5 cycles after sample 7.
        do_reset();
        for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b1, hs);
        repeat (5) step(1'b0, '0, 1'b1, hs);
        for (int i = 8; i <= 16; i++) step(1'b1, DW'(i), 1'b1, hs);
        drain(20);

        // Reset after the 10th output word, then a fresh frame.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b1, hs);
        for (int i = 0; i < 40 && cnt < 10; i++) begin
            step(1'b0, '0, 1'b1, hs);
            if (hs) cnt++;
        end
        chk("rst_wait", 32'(cnt), 10);
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, DW'(200 + i), 1'b1, hs);
        chk("post_rst_idx", 32'(frm_idx), 0);
        drain(20);

        // Random traffic on both sides.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 7), DW'($urandom),
                 1'($urandom_range(0, 1)), hs);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame, a power of two.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fir_valid, input, 1, fir_d holds a valid filter output this cycle.
REQ-006 SHALL have port fir_d, input, DATA_W, signed filter output sample.
REQ-007 SHALL have port frm_ready, input, 1, downstream FFT accepts the current word.
REQ-008 SHALL have port frm_valid, output, 1, frm_data/frm_idx/frm_last are valid.
REQ-009 SHALL have port frm_data, output, DATA_W, the sample being presented.
REQ-010 SHALL have port frm_idx, output, log2(FRAME_LEN), position of the sample within its frame.
REQ-011 SHALL have port frm_last, output, 1, asserted when frm_idx equals FRAME_LEN-1.
REQ-012 SHALL have port overflow, output, 1, sticky flag; at least one input sample was dropped.

Function
REQ-013 SHALL hold two banks (ping-pong), each storing FRAME_LEN samples of DATA_W bits.
REQ-014 SHALL keep a per-bank state: EMPTY -> FILLING on the first write; FILLING -> FULL on the write at index FRAME_LEN-1; FULL -> DRAINING on the first read handshake; DRAINING -> EMPTY on the handshake with frm_last=1.
REQ-015 SHALL write fir_d into bank wr_bank at wr_idx on each cycle with fir_valid=1, provided wr_bank is EMPTY or FILLING at that edge; wr_idx then increments.
REQ-016 SHALL, on the write at wr_idx=FRAME_LEN-1, wrap wr_idx to 0 and toggle wr_bank.
REQ-017 SHALL drop a sample arriving while wr_bank is FULL or DRAINING, set overflow, and leave wr_idx and wr_bank unchanged.
REQ-018 SHALL evaluate the drop condition of REQ-017 on the pre-edge bank state, so a bank freed on the same edge still causes that sample to drop.
REQ-019 SHALL, when fir_valid is low, retain a partially filled bank and its wr_idx; filling resumes when fir_valid returns.
REQ-020 SHALL drive frm_valid=1 exactly when bank rd_bank is FULL or DRAINING.
REQ-021 SHALL drive frm_data and frm_idx from the registers of rd_bank at rd_idx, with no extra read latency.
REQ-022 SHALL assert frm_valid on the cycle after the edge that writes the last sample of a frame (fill-to-output latency of 1 cycle).
REQ-023 SHALL advance rd_idx only on a handshake (frm_valid & frm_ready).
REQ-024 SHALL, on the handshake with frm_last=1, wrap rd_idx to 0, free the bank and toggle rd_bank.
REQ-025 SHALL hold frm_data, frm_idx and frm_valid stable while frm_valid=1 and frm_ready=0.
REQ-026 SHALL allow a write to one bank and a read from the other bank on the same cycle with no interaction.
REQ-027 SHALL present samples in arrival order, index 0 first, without changing the value or width of any sample.
REQ-028 SHALL never clear overflow except by reset.

Reset
REQ-029 SHALL, while rst=0, force frm_valid=0, frm_idx=0, frm_last=0, frm_data=0, overflow=0, wr_idx=0, rd_idx=0, wr_bank=0, rd_bank=0, and both banks to EMPTY.
REQ-030 SHALL discard any partial or full frame when reset is asserted mid-operation; sample storage contents need not be cleared.

Structure
REQ-031 SHALL take DATA_W and FRAME_LEN defaults and the bank-state encoding (EMPTY, FILLING, FULL, DRAINING) from the shared package fft_pkg.
REQ-032 SHALL instantiate one sub-module, frame_bank, twice: a FRAME_LEN x DATA_W register file with one write port, a combinational read port, and state tracking.

Verification
REQ-033 SHALL cover: reset, then 16 samples 1..16 with fir_valid=1 and frm_ready=1 -> frm_valid rises 1 cycle after sample 16; frm_data=1..16, frm_idx=0..15, frm_last only on 16.
REQ-034 SHALL cover: a continuous stream of 48 samples with frm_ready=1 -> three frames output in order, overflow stays 0.
REQ-035 SHALL cover: frm_ready=0 throughout, 40 samples -> banks hold 1..16 and 17..32; samples 33..40 dropped; overflow=1; after frm_ready=1, exactly 32 words are output.
REQ-036 SHALL cover: frm_ready toggled every cycle -> frm_data held during stalls, no sample repeated or skipped.
REQ-037 SHALL cover: fir_valid deasserted for 5 cycles after sample 7 -> frame still output as 16 contiguous samples with correct indices.
REQ-038 SHALL cover: rst pulsed low after the 10th output word of a frame -> all outputs 0 immediately; the next 16 inputs form a frame starting at frm_idx=0.
